pipe_div_seq_ctrl: RTL and testbench
====================================

Name: pipe_div_seq_ctrl

Overview:
Iterative divider controller. It sequences one restoring shift-subtract division step per clock over DEND_W cycles, reusing a single step datapath instead of DEND_W pipeline cells. It gives area-constrained users the same quotient/remainder results as the pipelined divider, using a valid/ready handshake on both sides. Divider-by-zero results are defined.

Parameters:
DEND_W  32  dividend and quotient width in bits; minimum 2
SOR_W   32  divisor and remainder width in bits; minimum 1, must be <= DEND_W

Ports:
clk          input   1              system clock; all logic on rising edge
rst          input   1              synchronous, active-high reset
in_valid     input   1              operand pair valid
in_ready     output  1              controller can accept operands
dividend_i   input   DEND_W         unsigned dividend
divisor_i    input   SOR_W          unsigned divisor
out_valid    output  1              result valid; held until accepted
out_ready    input   1              downstream accepts result
quotient_o   output  DEND_W         unsigned quotient
remainder_o  output  SOR_W          unsigned remainder
div0_o       output  1              divisor was zero (see Optional Feature)
busy_o       output  1              high whenever state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, quotient_o=0, remainder_o=0, div0_o=0, step counter=0, work registers=0.
- Reset mid-operation: aborts the division, returns to IDLE, and drops any pending result.
- FSM states: IDLE, CALC, DONE.
- in_ready = (state==IDLE). This is combinational from state only; there is no path from in_valid.
- IDLE: on in_valid:
  - load work register W (DEND_W+SOR_W+1 bits) = {0, dividend_i}.
  - latch D = divisor_i.
  - clear the counter.
  - go to CALC.
- CALC, one step per cycle:
  - S = W<<1.
  - if S[DEND_W+SOR_W:DEND_W] >= D: W = S - (D<<DEND_W) + 1; else W = S.
  - increment the counter.
- The extra MSB in W is mandatory. Without it, the shifted partial remainder overflows for D > 2^(SOR_W-1).
- After the step where the counter reaches DEND_W-1: go to DONE.
  - register quotient_o = W[DEND_W-1:0].
  - register remainder_o = W[DEND_W+SOR_W-1:DEND_W], taken from the post-step value.
  - out_valid = 1.
- Latency: the accept edge is edge 0. out_valid rises after edge DEND_W.
- DONE:
  - outputs and out_valid are held stable while out_ready=0.
  - on out_ready: out_valid=0 and go to IDLE.
  - results stay at their last value until the next completion.
- Throughput: one division per DEND_W+2 cycles minimum. DONE->IDLE costs one bubble; no accept is possible in DONE.
- in_valid while busy is ignored. The upstream holds it per handshake; the controller does not latch it.
- Divisor 0 without the macro: the algorithm naturally yields quotient=all ones and remainder=dividend[SOR_W-1:0]. div0_o=0.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
Macro DIV_ZERO_FAST_EN.
- Defined: in IDLE, an accept with divisor_i==0 skips CALC and goes directly to DONE on the accept edge.
  - quotient_o = all ones, remainder_o = dividend_i[SOR_W-1:0], div0_o=1.
  - latency is 1 cycle.
  - div0_o clears on the next accept with a nonzero divisor.
- Not defined: a zero divisor iterates normally. Results are identical and latency is DEND_W; div0_o is tied to 0.

Test Plan:
1. DEND_W=8, SOR_W=8: 200/7 accepted with out_ready=1 -> quotient=28, remainder=4; out_valid high exactly 8 cycles after accept; busy_o high during that interval.
2. 255/255 and 255/1 -> (1,0) and (255,0). Also 255/200 (divisor MSB set) -> (1,55); this checks the extra W bit.
3. 10/20 with out_ready=0 for 5 cycles after out_valid -> (0,10) held stable; in_ready=0 throughout; in_valid toggling meanwhile is ignored.
4. 100/0 -> quotient=255, remainder=100. Without macro: latency 8, div0_o=0. With DIV_ZERO_FAST_EN: latency 1, div0_o=1.
5. Accept 200/7, assert rst at CALC step 4 -> after the next edge all outputs are at reset values and in_ready=1; a subsequent 50/6 -> (8,2).
6. Random back-to-back stream of 1000 operand pairs with random out_ready -> every result matches a reference model; in_ready is never high outside IDLE.

Source files
------------

// File: rtl/pipe_div_seq_ctrl_if.sv
// Operand/result handshake bundle for the iterative divider controller.
// Both sides follow valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface pipe_div_seq_ctrl_if #(
    parameter int DEND_W = 32,
    parameter int SOR_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DEND_W-1:0] dividend_i;
    logic [SOR_W-1:0]  divisor_i;
    logic              out_valid;
    logic              out_ready;
    logic [DEND_W-1:0] quotient_o;
    logic [SOR_W-1:0]  remainder_o;
    logic              div0_o;
    logic              busy_o;

    modport master (
        output in_valid, dividend_i, divisor_i, out_ready,
        input  in_ready, out_valid, quotient_o, remainder_o, div0_o, busy_o
    );

    modport slave (
        input  in_valid, dividend_i, divisor_i, out_ready,
        output in_ready, out_valid, quotient_o, remainder_o, div0_o, busy_o
    );
endinterface

// File: rtl/pipe_div_seq_ctrl.sv
// Iterative restoring divider: one shift-subtract step per clock over DEND_W cycles.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes on the accept edge and raises div0_o.
module pipe_div_seq_ctrl #(
    parameter int DEND_W = 32,
    parameter int SOR_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    pipe_div_seq_ctrl_if.slave      bus_io,
    output logic [1:0]              state_o
);
    localparam int W_W   = DEND_W + SOR_W + 1;
    localparam int CNT_W = $clog2(DEND_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [W_W-1:0]    w_q;
    logic [W_W-1:0]    w_d;
    logic [SOR_W-1:0]  d_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DEND_W-1:0] quot_q;
    logic [SOR_W-1:0]  rem_q;
    logic              out_valid_q;
    logic [W_W-1:0]    shifted;
    logic [SOR_W:0]    top_sub;
`ifdef DIV_ZERO_FAST_EN
    logic              div0_q;
`endif

    // The top slice is SOR_W+1 bits wide so a divisor with its MSB set never overflows.
    always_comb begin
        shifted = w_q << 1;
        top_sub = shifted[W_W-1:DEND_W] - {1'b0, d_q};
        w_d     = shifted;
        if (shifted[W_W-1:DEND_W] >= {1'b0, d_q}) begin
            w_d = {top_sub, shifted[DEND_W-1:1], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            w_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            div0_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_io.in_valid) begin
                        w_q     <= {{(SOR_W + 1){1'b0}}, bus_io.dividend_i};
                        d_q     <= bus_io.divisor_i;
                        cnt_q   <= '0;
                        state_q <= CALC;
`ifdef DIV_ZERO_FAST_EN
                        // Zero divisor: publish the defined result directly, skipping CALC.
                        if (bus_io.divisor_i == '0) begin
                            quot_q      <= '1;
                            rem_q       <= bus_io.dividend_i[SOR_W-1:0];
                            div0_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            div0_q      <= 1'b0;
                        end
`endif
                    end
                end
                CALC: begin
                    w_q   <= w_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        quot_q      <= w_d[DEND_W-1:0];
                        rem_q       <= w_d[W_W-2:DEND_W];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_io.in_ready    = (state_q == IDLE);
    assign bus_io.busy_o      = (state_q != IDLE);
    assign bus_io.out_valid   = out_valid_q;
    assign bus_io.quotient_o  = quot_q;
    assign bus_io.remainder_o = rem_q;
`ifdef DIV_ZERO_FAST_EN
    assign bus_io.div0_o      = div0_q;
`else
    assign bus_io.div0_o      = 1'b0;
`endif
    assign state_o            = state_q;
endmodule

// File: tb/tb_pipe_div_seq_ctrl.sv
// Self-checking bench for pipe_div_seq_ctrl at DEND_W=SOR_W=8: directed table, reset abort, random stream.
module tb_pipe_div_seq_ctrl;
    localparam int DW = 8;
    localparam int SW = 8;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] dvd;
        logic [SW-1:0] dvs;
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        int            hold;
    } vec_t;

    logic clk;
    logic rst;
    logic [1:0] state_dbg;
    int n_tests = 0;
    int n_fail  = 0;
    bit rand_on = 1'b0;
    logic [DW+SW:0] exp_q[$];

    pipe_div_seq_ctrl_if #(.DEND_W(DW), .SOR_W(SW)) bus ();

    pipe_div_seq_ctrl #(.DEND_W(DW), .SOR_W(SW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus_io  (bus),
        .state_o (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference result straight from the arithmetic definition.
    function automatic logic [DW+SW:0] model(input logic [DW-1:0] a, input logic [SW-1:0] b);
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        logic          z;
        z = (b == 0);
        if (z) begin
            q = '1;
            r = a[SW-1:0];
        end else begin
            q = a / b;
            r = SW'(a % b);
        end
        return {FAST & z, q, r};
    endfunction

    task automatic run_vec(input logic [DW-1:0] a, input logic [SW-1:0] b,
                           input logic [DW-1:0] q, input logic [SW-1:0] r, input int hold);
        int t;
        int edge_n;
        int exp_edge;
        logic exp_d0;
        exp_d0   = FAST && (b == 0);
        exp_edge = exp_d0 ? 0 : DW;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("in_ready_before_accept", bus.in_ready, 1);
        bus.in_valid   = 1'b1;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        edge_n = 0;
        while (!bus.out_valid && edge_n < 50) begin
            chk("busy_during_calc", bus.busy_o, 1);
            chk("in_ready_during_calc", bus.in_ready, 0);
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.dividend_i = DW'($urandom);
            bus.divisor_i  = SW'($urandom);
            @(posedge clk); #1; edge_n++;
        end
        chk("out_valid_edge", edge_n, exp_edge);
        chk("quotient", bus.quotient_o, q);
        chk("remainder", bus.remainder_o, r);
        chk("div0", bus.div0_o, exp_d0);
        chk("busy_in_done", bus.busy_o, 1);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.dividend_i = DW'($urandom);
            bus.divisor_i  = SW'($urandom);
            @(posedge clk); #1;
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_quotient", bus.quotient_o, q);
            chk("hold_remainder", bus.remainder_o, r);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("release_out_valid", bus.out_valid, 0);
        chk("release_in_ready", bus.in_ready, 1);
        chk("release_busy", bus.busy_o, 0);
        chk("kept_quotient", bus.quotient_o, q);
        chk("kept_remainder", bus.remainder_o, r);
    endtask

    // Scoreboard: push on accept, pop on result transfer.
    always @(negedge clk) begin
        if (rand_on && !rst) begin
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.dividend_i, bus.divisor_i));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("rand_result", {bus.div0_o, bus.quotient_o, bus.remainder_o}, exp_q.pop_front());
                end
            end
            chk("rand_in_ready_while_busy", bus.in_ready && bus.busy_o, 0);
        end
    end

    always @(posedge clk) begin
        if (rand_on) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        vec_t vecs[9];
        int   t;
        bit   acc;
        logic [SW-1:0] b;

        vecs[0] = '{dvd: 200, dvs: 7,   q: 28,  r: 4,   hold: 0};
        vecs[1] = '{dvd: 255, dvs: 255, q: 1,   r: 0,   hold: 0};
        vecs[2] = '{dvd: 255, dvs: 1,   q: 255, r: 0,   hold: 1};
        vecs[3] = '{dvd: 255, dvs: 200, q: 1,   r: 55,  hold: 2};
        vecs[4] = '{dvd: 10,  dvs: 20,  q: 0,   r: 10,  hold: 5};
        vecs[5] = '{dvd: 0,   dvs: 200, q: 0,   r: 0,   hold: 1};
        vecs[6] = '{dvd: 7,   dvs: 0,   q: 255, r: 7,   hold: 0};
        vecs[7] = '{dvd: 100, dvs: 0,   q: 255, r: 100, hold: 3};
        vecs[8] = '{dvd: 9,   dvs: 3,   q: 3,   r: 0,   hold: 0};

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_quotient", bus.quotient_o, 0);
        chk("reset_remainder", bus.remainder_o, 0);
        chk("reset_div0", bus.div0_o, 0);
        chk("reset_busy", bus.busy_o, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].hold);

        // Abort at CALC step 4, then a clean division.
        bus.in_valid   = 1'b1;
        bus.dividend_i = 8'd200;
        bus.divisor_i  = 8'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pre_abort_busy", bus.busy_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_quotient", bus.quotient_o, 0);
        chk("abort_remainder", bus.remainder_o, 0);
        chk("abort_div0", bus.div0_o, 0);
        chk("abort_busy", bus.busy_o, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        run_vec(8'd50, 8'd6, 8'd8, 8'd2, 0);

        // Random back-to-back stream with random out_ready.
        rand_on = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = SW'($urandom) | 8'h80;
                default: b = SW'($urandom);
            endcase
            bus.dividend_i = DW'($urandom);
            bus.divisor_i  = b;
            bus.in_valid   = 1'b1;
            t = 0;
            do begin
                acc = bus.in_ready;
                @(posedge clk); #1; t++;
            end while (!acc && t < 100);
            if (!acc) chk("rand_accept_timeout", 0, 1);
        end
        bus.in_valid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk); #1; t++;
        end
        chk("rand_drain", exp_q.size(), 0);
        rand_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
